score_stream_tx: RTL and testbench
==================================

# score_stream_tx

Stream source that reads a frame of DATA_NUM scores from a synchronous-read BRAM and emits them in address order on a valid/ready stream, with out_last on the final element. It is the producer for the max-search stage: its out_valid/out_data/out_last/next_ready connect directly to that stage's in_valid/in_data/in_last/this_ready. A 3-entry output FIFO absorbs the 1-cycle BRAM read latency, so backpressure never loses data and sustained throughput is 1 element/cycle.

## Interface
- DATA_WIDTH, 11, score width in bits
- DATA_NUM, 15486, elements per frame (≥1)
- INDEX_WIDTH, $clog2(DATA_NUM), BRAM address width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to stream one frame; sampled only in IDLE
- abort  in  1  synchronous frame abort; honoured only when busy
- busy  out  1  high while a frame is active (state != IDLE)
- done  out  1  one-cycle pulse after the last element handshakes
- bram_en  out  1  read enable
- bram_addr  out  INDEX_WIDTH  read address
- bram_dout  in  DATA_WIDTH  read data, valid the cycle after bram_en
- out_valid  out  1  output element valid
- next_ready  in  1  downstream ready
- out_data  out  DATA_WIDTH  element; 0 when out_valid low
- out_last  out  1  high with the element from address DATA_NUM-1; 0 when out_valid low

## Operation
- States: IDLE, RUN (issuing reads), DRAIN (all reads issued, FIFO emptying).
- IDLE: start=1 → RUN, read address counter cleared to 0. start while busy is ignored.
- Read issue: bram_en = (state==RUN) && (fifo_count + inflight < 3); uses registered values only (no combinational path from next_ready to bram_en). bram_addr = read counter; counter increments on each issue.
- Issuing address DATA_NUM-1 → DRAIN at the same edge.
- inflight is set on an issue and cleared at the following edge, when bram_dout is written into the FIFO together with a last flag (= issued address was DATA_NUM-1).
- The FIFO head drives out_valid/out_data/out_last. Pop on out_valid && next_ready. Push and pop in the same cycle are both performed; count unchanged.
- DRAIN: when the element with last flag pops → IDLE, done=1 for exactly one cycle.
- abort while busy: FIFO flushed, read counter cleared, any in-flight read discarded on return, → IDLE at the next edge; no done pulse. abort in IDLE has no effect; abort has priority over start in the same cycle.
- DATA_NUM=1: the single element carries out_last; RUN → DRAIN on the first issue.
- Counter compares use DATA_NUM-1 at INDEX_WIDTH bits; the address never wraps past DATA_NUM-1.

## Timing
- Reset values: busy 0, done 0, bram_en 0, bram_addr 0, out_valid 0, out_data 0, out_last 0; FIFO empty, inflight 0, state IDLE. Reset mid-frame discards everything; there is no done pulse.
- start sampled at edge E0 → bram_en=1, addr 0 during cycle E0–E1 → data captured at E2 → out_valid high from E2 (first element 2 cycles after start).
- next_ready held high: one element per cycle, DATA_NUM+2 cycles from the start edge to the edge after the last handshake, at which done pulses and busy falls.
- Stall: out_valid, out_data and out_last hold stable while next_ready=0. At most 3 elements are buffered; after that, bram_en stays low.
- out_valid never drops without a handshake, except on abort or reset.

## Test plan
- DATA_NUM=8, BRAM[i]=i+100, next_ready=1: out_data 100..107 on consecutive cycles, out_last only with 107, done pulses once, the first valid arrives 2 cycles after start.
- Same frame with next_ready random at 50%: identical sequence, no drops or duplicates, data stable during stalls, bram_en never issued while fifo_count+inflight=3.
- next_ready=0 for 10 cycles after start: exactly 3 reads issued, out_data=100 held; release → 100..107 continuous.
- DATA_NUM=1, BRAM[0]=0x7FF: one beat with out_data 0x7FF, out_last=1, then done.
- abort 4 cycles into a stalled frame, then start again: no done for the first frame; second frame outputs 100..107 cleanly with no stale element.
- start pulsed during busy, and rst_n asserted mid-frame: the extra start is ignored (one frame, one done); reset drives all outputs to 0 immediately and the next start streams from address 0.

Source files
------------

// File: rtl/score_stream_tx.sv
// Frame streamer: reads DATA_NUM scores from a synchronous-read BRAM in address order
// and emits them on a valid/ready stream, with a 3-deep FIFO hiding the read latency.
module score_stream_tx #(
  parameter int DATA_WIDTH  = 11,
  parameter int DATA_NUM    = 15486,
  parameter int INDEX_WIDTH = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   bram_en_o,
  output logic [INDEX_WIDTH-1:0] bram_addr_o,
  input  logic [DATA_WIDTH-1:0]  bram_dout_i,
  output logic                   out_valid_o,
  input  logic                   next_ready_i,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic                   out_last_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam logic [INDEX_WIDTH-1:0] LastAddr = INDEX_WIDTH'(DATA_NUM - 1);

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] rdAddr_q, rdAddr_d;
  logic                   inflight_q, inflight_d;
  logic                   inflightLast_q, inflightLast_d;
  logic [1:0]             count_q, count_d;
  logic [1:0]             wrPtr_q, wrPtr_d;
  logic [1:0]             rdPtr_q, rdPtr_d;
  logic                   done_q, done_d;
  logic [DATA_WIDTH-1:0]  fifoData_q [3];
  logic                   fifoLast_q [3];

  logic       issue;
  logic       push;
  logic       pop;
  logic       flush;
  logic       headValid;
  logic       headLast;
  logic [2:0] occupancy;

  function automatic logic [1:0] ptrInc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read issue looks only at registered occupancy, keeping next_ready off the bram_en path.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue     = (state_q == RUN) && (occupancy < 3'd3);
  assign flush     = abort_i && (state_q != IDLE);
  assign headValid = (count_q != 2'd0);
  assign headLast  = fifoLast_q[rdPtr_q];
  assign push      = inflight_q && !flush;
  assign pop       = headValid && next_ready_i && !flush;

  always_comb begin
    state_d        = state_q;
    rdAddr_d       = rdAddr_q;
    inflight_d     = issue;
    inflightLast_d = issue && (rdAddr_q == LastAddr);
    count_d        = count_q;
    wrPtr_d        = wrPtr_q;
    rdPtr_d        = rdPtr_q;
    done_d         = 1'b0;

    if (push) wrPtr_d = ptrInc(wrPtr_q);
    if (pop)  rdPtr_d = ptrInc(rdPtr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (issue && (rdAddr_q != LastAddr)) rdAddr_d = rdAddr_q + INDEX_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d  = RUN;
          rdAddr_d = '0;
        end
      end
      RUN: begin
        if (issue && (rdAddr_q == LastAddr)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && headLast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort drops buffered data and the pending read return, without a done pulse.
    if (flush) begin
      state_d        = IDLE;
      rdAddr_d       = '0;
      inflight_d     = 1'b0;
      inflightLast_d = 1'b0;
      count_d        = 2'd0;
      wrPtr_d        = 2'd0;
      rdPtr_d        = 2'd0;
      done_d         = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      rdAddr_q       <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      count_q        <= 2'd0;
      wrPtr_q        <= 2'd0;
      rdPtr_q        <= 2'd0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rdAddr_q       <= rdAddr_d;
      inflight_q     <= inflight_d;
      inflightLast_q <= inflightLast_d;
      count_q        <= count_d;
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      done_q         <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) begin
        fifoData_q[i] <= '0;
        fifoLast_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifoData_q[wrPtr_q] <= bram_dout_i;
      fifoLast_q[wrPtr_q] <= inflightLast_q;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign bram_en_o   = issue;
  assign bram_addr_o = rdAddr_q;
  assign out_valid_o = headValid;
  assign out_data_o  = headValid ? fifoData_q[rdPtr_q] : '0;
  assign out_last_o  = headValid && headLast;

endmodule

// File: tb/tb_score_stream_tx.sv
// Scoreboard bench for score_stream_tx: an 8-element frame instance and a 1-element instance.
module tb_score_stream_tx;

  localparam int DW = 11;
  localparam int DN = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start, abort, nextReady;
  logic          busy, done, bramEn, outValid, outLast;
  logic [2:0]    bramAddr;
  logic [DW-1:0] bramDout, outData;
  logic [DW-1:0] mem [DN];

  logic          start1, abort1, ready1;
  logic          busy1, done1, bramEn1, outValid1, outLast1;
  logic [0:0]    bramAddr1;
  logic [DW-1:0] bramDout1, outData1;

  exp_t          sbQ[$];
  int            checks = 0;
  int            errors = 0;
  int            doneCount = 0;
  int            issueCount = 0;
  int            occ = 0;
  logic          prevStall = 1'b0;
  logic          prevAbort = 1'b0;
  logic [DW-1:0] prevData = '0;
  logic          prevLast = 1'b0;

  always #5 clk = ~clk;

  score_stream_tx #(.DATA_WIDTH(DW), .DATA_NUM(DN)) dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .bram_en_o(bramEn), .bram_addr_o(bramAddr),
    .bram_dout_i(bramDout), .out_valid_o(outValid), .next_ready_i(nextReady),
    .out_data_o(outData), .out_last_o(outLast)
  );

  score_stream_tx #(.DATA_WIDTH(DW), .DATA_NUM(1)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .start_i(start1), .abort_i(abort1),
    .busy_o(busy1), .done_o(done1), .bram_en_o(bramEn1), .bram_addr_o(bramAddr1),
    .bram_dout_i(bramDout1), .out_valid_o(outValid1), .next_ready_i(ready1),
    .out_data_o(outData1), .out_last_o(outLast1)
  );

  initial for (int i = 0; i < DN; i++) mem[i] = DW'(i + 100);

  always @(posedge clk) begin
    if (bramEn)  bramDout  <= mem[bramAddr];
    if (bramEn1) bramDout1 <= (bramAddr1 == 1'b0) ? 11'h7FF : 11'h000;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard, stall-stability and read-occupancy monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rstN) begin
      occ = 0;
      prevStall = 1'b0;
      prevAbort = 1'b0;
    end else begin
      if (outValid && nextReady) begin
        if (sbQ.size() == 0) checkOutput("unexpectedBeat", 1, 0);
        else begin
          e = sbQ.pop_front();
          checkOutput("data", outData, e.data);
          checkOutput("last", outLast, e.last);
        end
      end
      if (!outValid) begin
        checkOutput("idleData", outData, 0);
        checkOutput("idleLast", outLast, 0);
      end
      if (prevStall && !prevAbort) begin
        checkOutput("stallValid", outValid, 1);
        checkOutput("stallData", outData, prevData);
        checkOutput("stallLast", outLast, prevLast);
      end
      if (bramEn) begin
        checkOutput("enOccupancy", occ < 3, 1);
        issueCount++;
      end
      occ = occ + (bramEn ? 1 : 0) - ((outValid && nextReady) ? 1 : 0);
      if (abort && busy) occ = 0;
      if (done) doneCount++;
      prevStall = outValid && !nextReady;
      prevData  = outData;
      prevLast  = outLast;
      prevAbort = abort;
    end
  end

  task automatic applyStimulus();
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    issueCount = 0;
    for (int i = 0; i < DN; i++) begin
      e.data = DW'(i + 100);
      e.last = (i == DN - 1);
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, input bit randReady, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
      else if (randReady) begin
        @(posedge clk);
        #1;
        nextReady = 1'($urandom_range(0, 1));
      end
    end
    if (!seen) checkOutput("doneTimeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, base, beats, dones1;
    rstN = 1'b0; start = 1'b0; abort = 1'b0; nextReady = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    #3;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstEn", bramEn, 0);
    checkOutput("rstAddr", bramAddr, 0);
    checkOutput("rstValid", outValid, 0);
    checkOutput("rstData", outData, 0);
    checkOutput("rstLast", outLast, 0);
    checkOutput("rstValid1", outValid1, 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;

    $display("[TB] full-rate frame");
    base = doneCount;
    applyStimulus();
    @(negedge clk);
    checkOutput("firstEn", bramEn, 1);
    checkOutput("firstAddr", bramAddr, 0);
    checkOutput("busyHigh", busy, 1);
    @(negedge clk);
    checkOutput("validAt1", outValid, 0);
    @(negedge clk);
    checkOutput("validAt2", outValid, 1);
    waitDone(50, 1'b0, cyc);
    checkOutput("frameCycles", cyc + 2, DN + 2);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("doneOnce", doneCount - base, 1);
    checkOutput("busyLow", busy, 0);
    checkOutput("sbEmpty", sbQ.size(), 0);

    $display("[TB] random backpressure frame");
    base = doneCount;
    nextReady = 1'b0;
    applyStimulus();
    waitDone(300, 1'b1, cyc);
    @(posedge clk);
    #1 nextReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("randDoneOnce", doneCount - base, 1);
    checkOutput("randSbEmpty", sbQ.size(), 0);

    $display("[TB] stalled start");
    base = doneCount;
    nextReady = 1'b0;
    applyStimulus();
    repeat (10) @(negedge clk);
    checkOutput("stallIssues", issueCount, 3);
    checkOutput("stallHeadValid", outValid, 1);
    checkOutput("stallHeadData", outData, 100);
    @(posedge clk);
    #1 nextReady = 1'b1;
    waitDone(50, 1'b0, cyc);
    checkOutput("releaseCycles", cyc, DN + 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stallDoneOnce", doneCount - base, 1);
    checkOutput("stallSbEmpty", sbQ.size(), 0);

    $display("[TB] abort then restart");
    base = doneCount;
    nextReady = 1'b0;
    applyStimulus();
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    sbQ.delete();
    @(negedge clk);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortValid", outValid, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abortNoDone", doneCount - base, 0);
    nextReady = 1'b1;
    applyStimulus();
    waitDone(50, 1'b0, cyc);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("restartDoneOnce", doneCount - base, 1);
    checkOutput("restartSbEmpty", sbQ.size(), 0);

    $display("[TB] start while busy");
    base = doneCount;
    applyStimulus();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(50, 1'b0, cyc);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("extraStartDone", doneCount - base, 1);
    checkOutput("extraStartBusy", busy, 0);
    checkOutput("extraStartSb", sbQ.size(), 0);

    $display("[TB] reset mid-frame");
    applyStimulus();
    repeat (4) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstEn", bramEn, 0);
    checkOutput("midRstAddr", bramAddr, 0);
    checkOutput("midRstValid", outValid, 0);
    checkOutput("midRstData", outData, 0);
    checkOutput("midRstLast", outLast, 0);
    sbQ.delete();
    @(posedge clk);
    #1 rstN = 1'b1;
    base = doneCount;
    applyStimulus();
    waitDone(50, 1'b0, cyc);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("postRstDone", doneCount - base, 1);
    checkOutput("postRstSb", sbQ.size(), 0);

    $display("[TB] single-element frame");
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    beats = 0;
    dones1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (outValid1) begin
        beats++;
        checkOutput("oneData", outData1, 11'h7FF);
        checkOutput("oneLast", outLast1, 1);
      end
      if (done1) dones1++;
    end
    checkOutput("oneBeats", beats, 1);
    checkOutput("oneDone", dones1, 1);
    checkOutput("oneBusy", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
